// File: rtl/axi_pmu_counters.sv
// axi_pmu_counters: AXI4-Lite performance-monitoring unit.
//
// Holds N_COUNTERS event counters (COUNTER_WIDTH bits each) plus CTRL, ENABLE,
// OVF (write-1-to-clear) and IRQMASK registers, all on one clock.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET  - clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*/AR*/R*    - AXI4-Lite slave (64-bit data)
//   events                    - per-counter increment strobe
//   overflow_irq              - registered OR of (OVF & IRQMASK)
//
// Optional feature: define PMU_SNAPSHOT_EN to add shadow counters captured by
// CTRL.SNAP; counter reads then return the shadow copy.
module axi_pmu_counters #(
    parameter int unsigned                         C_S_AXI_DATA_WIDTH = 64,
    parameter int unsigned                         C_S_AXI_ADDR_WIDTH = 64,
    parameter int unsigned                         N_COUNTERS         = 16,
    parameter int unsigned                         COUNTER_WIDTH      = 64,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]       BASE_ADDR          = 'hFFF5100000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [N_COUNTERS-1:0]           events,
    output logic                            overflow_irq
);

    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_CTRL = N_COUNTERS;
    localparam int unsigned IDX_EN   = N_COUNTERS + 1;
    localparam int unsigned IDX_OVF  = N_COUNTERS + 2;
    localparam int unsigned IDX_MASK = N_COUNTERS + 3;
    localparam int unsigned N_REGS   = N_COUNTERS + 4;

    typedef enum logic [1:0] {WIdle, WAcc, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAcc, RData} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [COUNTER_WIDTH-1:0] cnt_q [N_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [N_COUNTERS];
    logic                     gen_q, gen_d;
    logic [N_COUNTERS-1:0]    enable_q, enable_d;
    logic [N_COUNTERS-1:0]    ovf_q, ovf_d;
    logic [N_COUNTERS-1:0]    irqmask_q, irqmask_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [63:0]              rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;
    logic                     irq_q;

    logic [AW-1:0] w_idx, r_idx;
    logic [63:0]   wmask;
    logic          wr, clr;
`ifdef PMU_SNAPSHOT_EN
    logic [COUNTER_WIDTH-1:0] shadow_q [N_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_d [N_COUNTERS];
    logic                     snap;
`endif

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Write address/data are still held by the master during WAcc, so the
    // commit uses the live bus values on that edge.
    assign w_idx = (S_AXI_AWADDR - BASE_ADDR) >> 3;
    assign r_idx = (S_AXI_ARADDR - BASE_ADDR) >> 3;
    assign wr    = (w_state_q == WAcc);

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            wmask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
        end
    end

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [63:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    // Handshake FSMs
    always_comb begin
        w_state_d     = w_state_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (w_state_q)
            WIdle: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = WAcc;
            WAcc: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                w_state_d     = WResp;
            end
            WResp: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state_q)
            RIdle: if (S_AXI_ARVALID) r_state_d = RAcc;
            RAcc: begin
                S_AXI_ARREADY = 1'b1;
                r_state_d     = RData;
            end
            RData: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_state_d = RIdle;
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Register file next state
    always_comb begin
        logic ctrl_wr;
        logic ovf_wr;
        logic [N_COUNTERS-1:0] ovf_set;
        logic [N_COUNTERS-1:0] w1c;
        gen_d     = gen_q;
        enable_d  = enable_q;
        irqmask_d = irqmask_q;
        cnt_d     = cnt_q;
        ovf_set   = '0;
        w1c       = '0;
        bresp_d   = bresp_q;
        ctrl_wr   = wr && (w_idx == AW'(IDX_CTRL));
        ovf_wr    = wr && (w_idx == AW'(IDX_OVF));
        clr       = ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
        if (wr) bresp_d = (w_idx < AW'(N_REGS)) ? 2'b00 : 2'b10;
        if (ctrl_wr && S_AXI_WSTRB[0]) gen_d = S_AXI_WDATA[0];
        if (wr && (w_idx == AW'(IDX_EN))) begin
            enable_d = N_COUNTERS'(merge(64'(enable_q), S_AXI_WDATA, wmask));
        end
        if (wr && (w_idx == AW'(IDX_MASK))) begin
            irqmask_d = N_COUNTERS'(merge(64'(irqmask_q), S_AXI_WDATA, wmask));
        end
        if (ovf_wr) w1c = N_COUNTERS'(S_AXI_WDATA & wmask);
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            if (clr) begin
                cnt_d[i] = '0;
            end else if (wr && (w_idx == AW'(i))) begin
                // Software write beats a same-edge increment; no overflow.
                cnt_d[i] = COUNTER_WIDTH'(merge(64'(cnt_q[i]), S_AXI_WDATA, wmask));
            end else if (gen_q && enable_q[i] && events[i]) begin
                if (&cnt_q[i]) begin
                    cnt_d[i]   = '0;
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
                end
            end
        end
        // A new overflow wins over a same-edge W1C.
        ovf_d = clr ? '0 : ((ovf_q & ~w1c) | ovf_set);
    end

`ifdef PMU_SNAPSHOT_EN
    assign snap = wr && (w_idx == AW'(IDX_CTRL)) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];

    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            if (clr) begin
                shadow_d[i] = '0;
            end else if (snap) begin
                shadow_d[i] = cnt_q[i];
            end else if (wr && (w_idx == AW'(i))) begin
                shadow_d[i] = COUNTER_WIDTH'(merge(64'(shadow_q[i]), S_AXI_WDATA, wmask));
            end
        end
    end
`endif

    // Read mux, sampled on the RAcc edge
    always_comb begin
        rdata_d = '0;
        rresp_d = (r_idx < AW'(N_REGS)) ? 2'b00 : 2'b10;
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            if (r_idx == AW'(i)) begin
`ifdef PMU_SNAPSHOT_EN
                rdata_d = 64'(shadow_q[i]);
`else
                rdata_d = 64'(cnt_q[i]);
`endif
            end
        end
        if (r_idx == AW'(IDX_CTRL)) rdata_d = {63'd0, gen_q};
        if (r_idx == AW'(IDX_EN))   rdata_d = 64'(enable_q);
        if (r_idx == AW'(IDX_OVF))  rdata_d = 64'(ovf_q);
        if (r_idx == AW'(IDX_MASK)) rdata_d = 64'(irqmask_q);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            gen_q     <= 1'b0;
            enable_q  <= '0;
            ovf_q     <= '0;
            irqmask_q <= '0;
            bresp_q   <= 2'b00;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < N_COUNTERS; i++) begin
                cnt_q[i] <= '0;
`ifdef PMU_SNAPSHOT_EN
                shadow_q[i] <= '0;
`endif
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            gen_q     <= gen_d;
            enable_q  <= enable_d;
            ovf_q     <= ovf_d;
            irqmask_q <= irqmask_d;
            bresp_q   <= bresp_d;
            irq_q     <= |(ovf_q & irqmask_q);
            cnt_q     <= cnt_d;
`ifdef PMU_SNAPSHOT_EN
            shadow_q  <= shadow_d;
`endif
            if (r_state_q == RAcc) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign overflow_irq = irq_q;

endmodule

// File: tb/tb_axi_pmu_counters.sv
// Self-checking bench for axi_pmu_counters (8-bit counters, 16 counters).
module tb_axi_pmu_counters;
    localparam int unsigned N  = 16;
    localparam int unsigned CW = 8;
    localparam logic [63:0] BASE = 64'hFFF5100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [7:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [N-1:0] events;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q [$];   // {rresp, rdata}
    logic [1:0]  exp_b_q [$];

    always #5 clk = ~clk;

    axi_pmu_counters #(
        .C_S_AXI_DATA_WIDTH(64),
        .C_S_AXI_ADDR_WIDTH(64),
        .N_COUNTERS        (N),
        .COUNTER_WIDTH     (CW),
        .BASE_ADDR         (BASE)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .events       (events),
        .overflow_irq (irq)
    );

    function automatic logic [63:0] ra(input int unsigned idx);
        return BASE + 64'(idx) * 64'd8;
    endfunction

    // ev_drop: event bits released right after the write-commit edge.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [N-1:0] ev_drop,
                             output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (!(awready && wready)) begin
            errors++; $display("FAIL aw_w_ready_timeout got 0 want 1");
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; events = events & ~ev_drop; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (!bvalid) begin errors++; $display("FAIL bvalid_timeout got 0 want 1"); end
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [65:0] obs);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (!arready) begin errors++; $display("FAIL arready_timeout got 0 want 1"); end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (!rvalid) begin errors++; $display("FAIL rvalid_timeout got 0 want 1"); end
        obs = {rresp, rdata};
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic pulse(input int idx, input int cycles);
        @(posedge clk); #1;
        events[idx] = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        events[idx] = 1'b0;
    endtask

    task automatic test_reset;
        logic [65:0] obs, e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {awready, wready, bvalid, arready, rvalid, irq});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 68'd0) begin
            errors++; $display("FAIL reset_resp_data got %h want 0", {bresp, rresp, rdata});
        end
        // Latency: ARREADY one cycle after ARVALID, RVALID one cycle after that.
        @(posedge clk); #1;
        araddr = ra(0); arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b0) begin errors++; $display("FAIL arready_early got %b want 0", arready); end
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL arready_plus1 got %b want 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        exp_q.push_back({2'b00, 64'd0});
        e = exp_q.pop_front();
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rvalid_plus2_cnt0 got v=%b %h want v=1 %h", rvalid, {rresp, rdata}, e);
        end
        @(posedge clk); #1 rready = 1'b0;
        exp_q.push_back({2'b00, 64'd0});
        axi_read(ra(N + 2), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_ovf got %h want %h", obs, e); end
    endtask

    task automatic test_count;
        logic [65:0] obs, e;
        logic [1:0] b;
        exp_b_q.push_back(2'b00);
        axi_write(ra(N), 64'h1, 8'hFF, '0, b);
        exp_b_q.push_back(2'b00);
        axi_write(ra(N + 1), 64'h1, 8'hFF, '0, b);
        checks++;
        if (b !== exp_b_q[1]) begin errors++; $display("FAIL bresp_ok got %b want 00", b); end
        void'(exp_b_q.pop_front()); void'(exp_b_q.pop_front());
        pulse(0, 5);
        exp_q.push_back({2'b00, 64'd5});
        axi_read(ra(0), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL count_cnt0 got %h want %h", obs, e); end
        exp_q.push_back({2'b00, 64'd0});
        axi_read(ra(1), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL count_cnt1 got %h want %h", obs, e); end
    endtask

    task automatic test_overflow;
        logic [65:0] obs, e;
        logic [1:0] b;
        axi_write(ra(0), 64'hFE, 8'hFF, '0, b);
        axi_write(ra(N + 3), 64'h1, 8'hFF, '0, b);
        pulse(0, 2);
        // OVF has just set on the last edge; the irq follows one edge later.
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        exp_q.push_back({2'b00, 64'd0});
        exp_q.push_back({2'b00, 64'd1});
        axi_read(ra(0), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL wrap_cnt0 got %h want %h", obs, e); end
        axi_read(ra(N + 2), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL ovf_set got %h want %h", obs, e); end
        axi_write(ra(N + 2), 64'h1, 8'hFF, '0, b);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_collision;
        logic [65:0] obs, e;
        logic [1:0] b;
        axi_write(ra(N + 1), 64'h5, 8'hFF, '0, b);
        events[2] = 1'b1;
        axi_write(ra(2), 64'h40, 8'hFF, N'(4), b);
        exp_q.push_back({2'b00, 64'h40});
        axi_read(ra(2), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL write_vs_inc got %h want %h", obs, e); end
        exp_q.push_back({2'b00, 64'd0});
        axi_read(ra(N + 2), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL write_no_ovf got %h want %h", obs, e); end
    endtask

    task automatic test_width_err;
        logic [65:0] obs, e;
        logic [1:0] b;
        exp_q.push_back({2'b10, 64'd0});
        axi_read(ra(N + 4), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL slverr_read got %h want %h", obs, e); end
        exp_b_q.push_back(2'b10);
        axi_write(ra(N + 4), 64'hFFFF, 8'hFF, '0, b);
        checks++;
        if (b !== exp_b_q.pop_front()) begin errors++; $display("FAIL slverr_write got %b want 10", b); end
        axi_write(ra(N + 1), 64'hFFFF, 8'h01, '0, b);
        exp_q.push_back({2'b00, 64'h00FF});
        axi_read(ra(N + 1), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL wstrb_enable got %h want %h", obs, e); end
        axi_write(ra(3), 64'h1234, 8'hFF, '0, b);
        exp_q.push_back({2'b00, 64'h34});
        axi_read(ra(3), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL cnt_truncate got %h want %h", obs, e); end
        pulse(0, 3);
        axi_write(ra(N), 64'h3, 8'hFF, '0, b);
        exp_q.push_back({2'b00, 64'd0});
        exp_q.push_back({2'b00, 64'd1});
        axi_read(ra(0), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL clr_cnt0 got %h want %h", obs, e); end
        axi_read(ra(N), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL ctrl_readback got %h want %h", obs, e); end
    endtask

    task automatic test_snapshot;
        logic [65:0] obs, e;
        logic [1:0] b;
        pulse(0, 3);
        axi_write(ra(N), 64'h5, 8'hFF, '0, b);
        pulse(0, 10);
`ifdef PMU_SNAPSHOT_EN
        exp_q.push_back({2'b00, 64'd3});
`else
        exp_q.push_back({2'b00, 64'd13});
`endif
        exp_q.push_back({2'b00, 64'd1});
        axi_read(ra(0), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL snapshot_cnt0 got %h want %h", obs, e); end
        axi_read(ra(N), obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL snap_reads0 got %h want %h", obs, e); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        events = '0;
        test_reset();
        test_count();
        test_overflow();
        test_collision();
        test_width_err();
        test_snapshot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
